// File: rtl/ibex_xif_csr_stim_engine_if.sv
// rtl/ibex_xif_csr_stim_engine_if.sv - CSR access bus between the stimulus engine and ibex_xif_cs_registers
interface ibex_xif_csr_stim_engine_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 12
);
   logic                 csr_access;
   logic                 csr_op_en;
   logic [1:0]           csr_op;
   logic [AddrWidth-1:0] csr_addr;
   logic [DataWidth-1:0] csr_wdata;
   logic [DataWidth-1:0] csr_rdata;
   logic                 illegal_csr_insn;

   modport master (
      output csr_access, csr_op_en, csr_op, csr_addr, csr_wdata,
      input  csr_rdata, illegal_csr_insn
   );

   modport slave (
      input  csr_access, csr_op_en, csr_op, csr_addr, csr_wdata,
      output csr_rdata, illegal_csr_insn
   );
endinterface

// File: rtl/ibex_xif_csr_stim_engine.sv
// rtl/ibex_xif_csr_stim_engine.sv - multi-channel CSR stimulus and response-checking engine
// Per-channel FIFOs, round-robin issue of one CSR access per cycle, registered check of each response.
module ibex_xif_csr_stim_engine #(
   parameter int  NumChan   = 2,
   parameter int  Depth     = 4,
   parameter int  DataWidth = 32,
   parameter int  AddrWidth = 12,
   parameter int  CntWidth  = 16,
   localparam int ChanW     = (NumChan > 1) ? $clog2(NumChan) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumChan-1:0]           req_valid_i,
   output logic [NumChan-1:0]           req_ready_o,
   input  logic [NumChan*2-1:0]         req_op_i,
   input  logic [NumChan*AddrWidth-1:0] req_addr_i,
   input  logic [NumChan*DataWidth-1:0] req_wdata_i,
   input  logic [NumChan*DataWidth-1:0] req_exp_rdata_i,
   input  logic [NumChan*DataWidth-1:0] req_exp_mask_i,
   input  logic [NumChan-1:0]           req_exp_illegal_i,
   ibex_xif_csr_stim_engine_if.master   csr,
   output logic                         rsp_valid_o,
   output logic [ChanW-1:0]             rsp_chan_o,
   output logic [DataWidth-1:0]         rsp_rdata_o,
   output logic                         rsp_illegal_o,
   output logic                         rsp_mismatch_o,
   input  logic                         drain_i,
   output logic [CntWidth-1:0]          op_cnt_o,
   output logic [CntWidth-1:0]          err_cnt_o,
   output logic                         done_o,
   output logic                         test_passed_o
);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   typedef struct packed {
      logic [1:0]           op;
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] wdata;
      logic [DataWidth-1:0] exp_rdata;
      logic [DataWidth-1:0] exp_mask;
      logic                 exp_illegal;
   } entry_t;

   entry_t             mem      [NumChan][Depth];
   entry_t             in_entry [NumChan];
   logic [PtrW-1:0]    wr_ptr   [NumChan];
   logic [PtrW-1:0]    rd_ptr   [NumChan];
   logic [PtrW:0]      count    [NumChan];
   logic [NumChan-1:0] empty, full, push, pop;

   logic [ChanW-1:0]   rr_ptr, gnt_chan, cand;
   logic               gnt_valid;
   entry_t             gnt_entry;

   logic               s1_valid;
   logic [ChanW-1:0]   s1_chan;
   logic [DataWidth-1:0] s1_exp_rdata, s1_exp_mask;
   logic               s1_exp_illegal;
   logic               mismatch;

   always_comb begin
      for (int c = 0; c < NumChan; c++) begin
         in_entry[c].op          = req_op_i[c*2 +: 2];
         in_entry[c].addr        = req_addr_i[c*AddrWidth +: AddrWidth];
         in_entry[c].wdata       = req_wdata_i[c*DataWidth +: DataWidth];
         in_entry[c].exp_rdata   = req_exp_rdata_i[c*DataWidth +: DataWidth];
         in_entry[c].exp_mask    = req_exp_mask_i[c*DataWidth +: DataWidth];
         in_entry[c].exp_illegal = req_exp_illegal_i[c];
         empty[c] = (count[c] == '0);
         full[c]  = (count[c] == (PtrW+1)'(Depth));
         // full is registered, so a same-cycle pop never makes room for this push
         push[c]  = req_valid_i[c] && !full[c];
      end
   end

   assign req_ready_o = ~full;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_chan  = '0;
      cand      = '0;
      pop       = '0;
      for (int i = 0; i < NumChan; i++) begin
         cand = ChanW'((int'(rr_ptr) + i) % NumChan);
         if (!gnt_valid && !empty[cand]) begin
            gnt_valid = 1'b1;
            gnt_chan  = cand;
         end
      end
      for (int c = 0; c < NumChan; c++) begin
         pop[c] = gnt_valid && (gnt_chan == ChanW'(c));
      end
      gnt_entry = mem[gnt_chan][rd_ptr[gnt_chan]];
   end

   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NumChan; c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= in_entry[c];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NumChan; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NumChan; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
            if (push[c] != pop[c]) count[c] <= push[c] ? count[c] + 1'b1 : count[c] - 1'b1;
         end
      end
   end

   assign mismatch = (((csr.csr_rdata ^ s1_exp_rdata) & s1_exp_mask) != '0) ||
                     (csr.illegal_csr_insn != s1_exp_illegal);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr         <= '0;
         s1_valid       <= 1'b0;
         s1_chan        <= '0;
         s1_exp_rdata   <= '0;
         s1_exp_mask    <= '0;
         s1_exp_illegal <= 1'b0;
         csr.csr_access <= 1'b0;
         csr.csr_op_en  <= 1'b0;
         csr.csr_op     <= '0;
         csr.csr_addr   <= '0;
         csr.csr_wdata  <= '0;
         rsp_valid_o    <= 1'b0;
         rsp_chan_o     <= '0;
         rsp_rdata_o    <= '0;
         rsp_illegal_o  <= 1'b0;
         rsp_mismatch_o <= 1'b0;
         op_cnt_o       <= '0;
         err_cnt_o      <= '0;
         done_o         <= 1'b0;
      end else begin
         s1_valid       <= gnt_valid;
         csr.csr_access <= gnt_valid;
         csr.csr_op_en  <= gnt_valid;
         if (gnt_valid) begin
            rr_ptr         <= (gnt_chan == ChanW'(NumChan - 1)) ? '0 : gnt_chan + 1'b1;
            s1_chan        <= gnt_chan;
            s1_exp_rdata   <= gnt_entry.exp_rdata;
            s1_exp_mask    <= gnt_entry.exp_mask;
            s1_exp_illegal <= gnt_entry.exp_illegal;
            csr.csr_op     <= gnt_entry.op;
            csr.csr_addr   <= gnt_entry.addr;
            csr.csr_wdata  <= gnt_entry.wdata;
            if (op_cnt_o != '1) op_cnt_o <= op_cnt_o + 1'b1;
         end
         rsp_valid_o <= s1_valid;
         if (s1_valid) begin
            rsp_chan_o     <= s1_chan;
            rsp_rdata_o    <= csr.csr_rdata;
            rsp_illegal_o  <= csr.illegal_csr_insn;
            rsp_mismatch_o <= mismatch;
            if (mismatch && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
         end
         // An empty S1 now means S2 is empty after this edge, so done lands right after the last response
         if (drain_i && (&empty) && !(|push) && !s1_valid) done_o <= 1'b1;
      end
   end

   assign test_passed_o = done_o && (err_cnt_o == '0);
endmodule

// File: tb/tb_ibex_xif_csr_stim_engine.sv
// tb/tb_ibex_xif_csr_stim_engine.sv - randomized self-checking bench for ibex_xif_csr_stim_engine
module tb_ibex_xif_csr_stim_engine;
   localparam int NumChan = 2;
   localparam int Depth   = 4;
   localparam int DW      = 32;
   localparam int AW      = 12;
   localparam int CW      = 16;

   logic clk    = 1'b0;
   logic rst_ni = 1'b1;
   always #5 clk = ~clk;

   logic [NumChan-1:0]    req_valid, req_ready, req_exp_illegal;
   logic [NumChan*2-1:0]  req_op;
   logic [NumChan*AW-1:0] req_addr;
   logic [NumChan*DW-1:0] req_wdata, req_exp_rdata, req_exp_mask;
   logic                  rsp_valid, rsp_illegal, rsp_mismatch, drain, done, test_passed;
   logic [0:0]            rsp_chan;
   logic [DW-1:0]         rsp_rdata;
   logic [CW-1:0]         op_cnt, err_cnt;

   ibex_xif_csr_stim_engine_if #(.DataWidth(DW), .AddrWidth(AW)) csr_bus ();

   logic [DW-1:0] csr_mem [4096];
   logic          ill_mem [4096];
   always_comb begin
      csr_bus.csr_rdata        = csr_mem[csr_bus.csr_addr];
      csr_bus.illegal_csr_insn = ill_mem[csr_bus.csr_addr];
   end

   ibex_xif_csr_stim_engine #(
      .NumChan(NumChan), .Depth(Depth), .DataWidth(DW), .AddrWidth(AW), .CntWidth(CW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_exp_rdata_i(req_exp_rdata),
      .req_exp_mask_i(req_exp_mask), .req_exp_illegal_i(req_exp_illegal),
      .csr(csr_bus),
      .rsp_valid_o(rsp_valid), .rsp_chan_o(rsp_chan), .rsp_rdata_o(rsp_rdata),
      .rsp_illegal_o(rsp_illegal), .rsp_mismatch_o(rsp_mismatch),
      .drain_i(drain), .op_cnt_o(op_cnt), .err_cnt_o(err_cnt),
      .done_o(done), .test_passed_o(test_passed)
   );

   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      logic [DW-1:0] exp_mask;
      logic          exp_ill;
   } req_t;

   req_t mq [NumChan][$];
   req_t drv_entry [NumChan];
   bit   drv_valid [NumChan];
   bit   drv_drain;

   int            m_rr, m_s1_chan, m_s2_chan, m_op_cnt, m_err_cnt;
   bit            m_s1_v, m_s2_v, m_s2_ill, m_s2_mis, m_done;
   req_t          m_s1;
   logic [1:0]    m_op;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_s2_rdata;

   int n_vec = 0, n_err = 0, cyc = 0;
   int rsp_chan_log[$], rsp_mis_log[$];
   int access_hi, last_rsp_cyc, done_rise_cyc;
   bit prev_done, saw_full1;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic req_t mk(logic [1:0] op, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                               logic [DW-1:0] exp, logic [DW-1:0] mask, logic ill);
      req_t r;
      r.op = op; r.addr = addr; r.wdata = wdata;
      r.exp_rdata = exp; r.exp_mask = mask; r.exp_ill = ill;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.op    = 2'($urandom_range(0, 3));
      r.addr  = AW'($urandom_range(0, 4095));
      r.wdata = $urandom;
      case ($urandom_range(0, 2))
         0:       r.exp_mask = '0;
         1:       r.exp_mask = '1;
         default: r.exp_mask = $urandom;
      endcase
      r.exp_rdata = ($urandom_range(0, 1) != 0) ? csr_mem[r.addr] : DW'($urandom);
      r.exp_ill   = ($urandom_range(0, 3) != 0) ? ill_mem[r.addr] : !ill_mem[r.addr];
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NumChan; c++) mq[c].delete();
      m_rr = 0; m_s1_v = 0; m_s2_v = 0; m_s1_chan = 0; m_s2_chan = 0;
      m_op = '0; m_addr = '0; m_wdata = '0;
      m_op_cnt = 0; m_err_cnt = 0; m_done = 0; prev_done = 0;
   endtask

   // Advance the reference model across one clock edge using the inputs about to be sampled
   task automatic model_edge();
      bit acc [NumChan];
      bit all_empty = 1'b1;
      bit any_acc = 1'b0;
      bit granted = 1'b0;
      for (int c = 0; c < NumChan; c++) begin
         acc[c]    = drv_valid[c] && (mq[c].size() < Depth);
         all_empty = all_empty && (mq[c].size() == 0);
         any_acc   = any_acc || acc[c];
      end
      if (drv_drain && all_empty && !any_acc && !m_s1_v) m_done = 1'b1;
      m_s2_v = m_s1_v;
      if (m_s1_v) begin
         m_s2_chan  = m_s1_chan;
         m_s2_rdata = csr_mem[m_s1.addr];
         m_s2_ill   = ill_mem[m_s1.addr];
         m_s2_mis   = (((m_s2_rdata ^ m_s1.exp_rdata) & m_s1.exp_mask) != 0) || (m_s2_ill != m_s1.exp_ill);
         if (m_s2_mis && m_err_cnt < 65535) m_err_cnt++;
      end
      for (int i = 0; i < NumChan; i++) begin
         int k = (m_rr + i) % NumChan;
         if (!granted && mq[k].size() > 0) begin
            granted   = 1'b1;
            m_s1      = mq[k].pop_front();
            m_s1_chan = k;
            m_rr      = (k + 1) % NumChan;
            if (m_op_cnt < 65535) m_op_cnt++;
            m_op = m_s1.op; m_addr = m_s1.addr; m_wdata = m_s1.wdata;
         end
      end
      m_s1_v = granted;
      for (int c = 0; c < NumChan; c++) if (acc[c]) mq[c].push_back(drv_entry[c]);
   endtask

   task automatic check_outputs();
      for (int c = 0; c < NumChan; c++)
         check($sformatf("req_ready[%0d]", c), 64'(req_ready[c]), 64'(mq[c].size() < Depth));
      check("csr_access", 64'(csr_bus.csr_access), 64'(m_s1_v));
      check("csr_op_en", 64'(csr_bus.csr_op_en), 64'(m_s1_v));
      check("csr_op", 64'(csr_bus.csr_op), 64'(m_op));
      check("csr_addr", 64'(csr_bus.csr_addr), 64'(m_addr));
      check("csr_wdata", 64'(csr_bus.csr_wdata), 64'(m_wdata));
      check("rsp_valid", 64'(rsp_valid), 64'(m_s2_v));
      if (m_s2_v) begin
         check("rsp_chan", 64'(rsp_chan), 64'(m_s2_chan));
         check("rsp_rdata", 64'(rsp_rdata), 64'(m_s2_rdata));
         check("rsp_illegal", 64'(rsp_illegal), 64'(m_s2_ill));
         check("rsp_mismatch", 64'(rsp_mismatch), 64'(m_s2_mis));
      end
      check("op_cnt", 64'(op_cnt), 64'(m_op_cnt));
      check("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
      check("done", 64'(done), 64'(m_done));
      check("test_passed", 64'(test_passed), 64'(m_done && m_err_cnt == 0));
      if (csr_bus.csr_access) access_hi++;
      if (rsp_valid) begin
         rsp_chan_log.push_back(int'(rsp_chan));
         rsp_mis_log.push_back(int'(rsp_mismatch));
         last_rsp_cyc = cyc;
      end
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_done = done;
      if (!req_ready[1]) saw_full1 = 1'b1;
   endtask

   task automatic apply_inputs();
      for (int c = 0; c < NumChan; c++) begin
         req_valid[c]              = drv_valid[c];
         req_op[c*2 +: 2]          = drv_entry[c].op;
         req_addr[c*AW +: AW]      = drv_entry[c].addr;
         req_wdata[c*DW +: DW]     = drv_entry[c].wdata;
         req_exp_rdata[c*DW +: DW] = drv_entry[c].exp_rdata;
         req_exp_mask[c*DW +: DW]  = drv_entry[c].exp_mask;
         req_exp_illegal[c]        = drv_entry[c].exp_ill;
      end
      drain = drv_drain;
   endtask

   task automatic clear_drv();
      for (int c = 0; c < NumChan; c++) begin
         drv_valid[c] = 1'b0;
         drv_entry[c] = '0;
      end
   endtask

   task automatic step();
      check_outputs();
      apply_inputs();
      #1;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(int n);
      clear_drv();
      repeat (n) step();
   endtask

   task automatic push1(int c, req_t r);
      clear_drv();
      drv_valid[c] = 1'b1;
      drv_entry[c] = r;
      step();
   endtask

   // Asynchronous reset asserted mid-cycle, released on a falling edge
   task automatic do_reset();
      clear_drv();
      drv_drain = 1'b0;
      apply_inputs();
      #2 rst_ni = 1'b0;
      model_reset();
      #1 check_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) begin
         csr_mem[a] = $urandom;
         ill_mem[a] = ($urandom_range(0, 7) == 0);
      end
      clear_drv();
      drv_drain = 1'b0;
      apply_inputs();
      model_reset();
      @(negedge clk);
      do_reset();

      csr_mem[12'h300] = 32'h1800; ill_mem[12'h300] = 1'b0;
      access_hi = 0; rsp_mis_log.delete();
      push1(0, mk(2'd0, 12'h300, 32'h0, 32'h1800, 32'hFFFF_FFFF, 1'b0));
      idle(5);
      check("single_access_cycles", 64'(access_hi), 64'd1);
      check("single_rsp_count", 64'(rsp_mis_log.size()), 64'd1);
      if (rsp_mis_log.size() > 0) check("single_mismatch", 64'(rsp_mis_log[0]), 64'd0);
      check("single_op_cnt", 64'(op_cnt), 64'd1);

      do_reset();
      rsp_chan_log.delete();
      for (int i = 0; i < 3; i++) begin
         for (int c = 0; c < NumChan; c++) begin
            drv_valid[c] = 1'b1;
            drv_entry[c] = mk(2'd1, AW'(12'h310 + c*16 + i), $urandom, 32'h0, 32'h0, ill_mem[12'h310 + c*16 + i]);
         end
         step();
      end
      idle(6);
      check("rr_count", 64'(rsp_chan_log.size()), 64'd6);
      for (int i = 0; i < rsp_chan_log.size() && i < 6; i++)
         check($sformatf("rr_order[%0d]", i), 64'(rsp_chan_log[i]), 64'(i % 2));

      do_reset();
      saw_full1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < NumChan; c++) begin
            drv_valid[c] = 1'b1;
            drv_entry[c] = rand_req();
         end
         step();
      end
      idle(12);
      check("bp_saw_full1", 64'(saw_full1), 64'd1);

      do_reset();
      rsp_mis_log.delete();
      csr_mem[12'h340] = 32'h0000_00F0; ill_mem[12'h340] = 1'b0;
      csr_mem[12'h341] = 32'h0;         ill_mem[12'h341] = 1'b1;
      push1(0, mk(2'd0, 12'h340, 32'h0, 32'h0, 32'h0000_000F, 1'b0));
      push1(0, mk(2'd0, 12'h340, 32'h0, 32'h0, 32'h0000_00FF, 1'b0));
      push1(0, mk(2'd0, 12'h341, 32'h0, 32'h0, 32'h0, 1'b0));
      idle(5);
      check("mask_rsp_count", 64'(rsp_mis_log.size()), 64'd3);
      if (rsp_mis_log.size() == 3) begin
         check("mask_narrow_pass", 64'(rsp_mis_log[0]), 64'd0);
         check("mask_wide_fail", 64'(rsp_mis_log[1]), 64'd1);
         check("illegal_fail", 64'(rsp_mis_log[2]), 64'd1);
      end
      check("mask_err_cnt", 64'(err_cnt), 64'd2);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         ill_mem[12'h350 + i] = 1'b0;
         push1(0, mk(2'd0, AW'(12'h350 + i), 32'h0, 32'h0, 32'h0, 1'b0));
      end
      clear_drv();
      drv_drain = 1'b1;
      last_rsp_cyc = -1; done_rise_cyc = -100;
      repeat (12) step();
      check("drain_done_latency", 64'(done_rise_cyc - last_rsp_cyc), 64'd1);
      check("drain_passed", 64'(test_passed), 64'd1);
      push1(0, mk(2'd0, 12'h340, 32'h0, 32'h0, 32'h0000_00FF, 1'b0));
      idle(6);
      check("drain_done_sticky", 64'(done), 64'd1);
      check("drain_failed_after_err", 64'(test_passed), 64'd0);
      check("drain_err_cnt", 64'(err_cnt), 64'd1);
      drv_drain = 1'b0;

      do_reset();
      clear_drv();
      drv_valid[0] = 1'b1; drv_entry[0] = mk(2'd0, 12'h360, 32'h0, 32'h0, 32'h0, 1'b0);
      drv_valid[1] = 1'b1; drv_entry[1] = mk(2'd0, 12'h370, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      drv_entry[0].addr = 12'h361; drv_entry[1].addr = 12'h371;
      step();
      drv_valid[1] = 1'b0; drv_entry[0].addr = 12'h362;
      step();
      idle(1);
      check("mid_s1_busy", 64'(csr_bus.csr_access), 64'd1);
      check("mid_s2_busy", 64'(rsp_valid), 64'd1);
      do_reset();
      rsp_chan_log.delete();
      idle(3);
      check("mid_no_rsp", 64'(rsp_chan_log.size()), 64'd0);
      check("mid_op_cnt", 64'(op_cnt), 64'd0);
      check("mid_ready", 64'(req_ready), 64'h3);
      drv_valid[0] = 1'b1; drv_entry[0] = mk(2'd1, 12'h3A0, 32'h0, 32'h0, 32'h0, 1'b0);
      drv_valid[1] = 1'b1; drv_entry[1] = mk(2'd1, 12'h3B0, 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      idle(1);
      check("mid_first_grant_ch0", 64'(csr_bus.csr_addr), 64'h3A0);
      idle(6);

      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NumChan; c++) begin
            drv_valid[c] = ($urandom_range(0, 9) < 6);
            drv_entry[c] = rand_req();
         end
         if (i == 200) do_reset();
         else step();
      end
      clear_drv();
      drv_drain = 1'b1;
      repeat (20) step();
      check("rand_final_done", 64'(done), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
